// File: rtl/attn_score_if.sv
// Handshake bundle for the streaming attention score engine: K and Q token
// inputs, the score output stream, the causal-mask control and the busy flag.
interface attn_score_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TOKEN_DIM  = 4,
  parameter int TOKEN_NUM  = 8
);
  localparam int CW = (TOKEN_NUM > 1) ? $clog2(TOKEN_NUM) : 1;

  logic                            causal_en;
  logic                            k_valid;
  logic                            k_ready;
  logic [DATA_WIDTH*TOKEN_DIM-1:0] k_data;
  logic                            q_valid;
  logic                            q_ready;
  logic [DATA_WIDTH*TOKEN_DIM-1:0] q_data;
  logic                            s_valid;
  logic                            s_ready;
  logic [DATA_WIDTH-1:0]           s_data;
  logic [CW-1:0]                   s_row;
  logic [CW-1:0]                   s_col;
  logic                            s_last;
  logic                            busy;

  modport slave (
    input  causal_en, k_valid, k_data, q_valid, q_data, s_ready,
    output k_ready, q_ready, s_valid, s_data, s_row, s_col, s_last, busy
  );

  modport master (
    output causal_en, k_valid, k_data, q_valid, q_data, s_ready,
    input  k_ready, q_ready, s_valid, s_data, s_row, s_col, s_last, busy
  );
endinterface

// File: rtl/attn_score_stream.sv
// Streaming QK^T score engine: buffers TOKEN_NUM keys, then for each query
// emits TOKEN_NUM scaled, saturated, optionally causally masked dot products.
module attn_score_stream #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int TOKEN_DIM   = 4,
  parameter int TOKEN_NUM   = 8,
  parameter int SCALE_SHIFT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  attn_score_if.slave  bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int TW    = DATA_WIDTH * TOKEN_DIM;
  localparam int CW    = (TOKEN_NUM > 1) ? $clog2(TOKEN_NUM) : 1;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int ACC_W = PW + $clog2(TOKEN_DIM);
  localparam int SH    = FRAC_BITS + SCALE_SHIFT;
  localparam logic [CW-1:0]           LAST  = CW'(TOKEN_NUM - 1);
  localparam logic signed [DW-1:0]    S_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] A_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] A_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {LOAD_K, WAIT_Q, EMIT} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_k_cnt;
  logic [CW-1:0]           r_row;
  logic [CW-1:0]           r_col;
  logic                    r_causal;
  logic                    r_k_ready;
  logic                    r_q_ready;
  logic                    r_busy;
  logic                    r_s_valid;
  logic                    r_s_last;
  logic signed [DW-1:0]    r_s_data;
  logic [CW-1:0]           r_s_row;
  logic [CW-1:0]           r_s_col;
  logic [TW-1:0]           r_kbuf [TOKEN_NUM];
  logic [TW-1:0]           r_q;

  logic                    w_k_acc;
  logic                    w_q_acc;
  logic                    w_s_hs;
  logic [CW-1:0]           w_col_sel;
  logic [TW-1:0]           w_q_sel;
  logic [TW-1:0]           w_k_sel;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [DW-1:0]    w_score;

  function automatic logic signed [PW-1:0] f_mul(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  // Floor shift (fixed-point rescale plus the 1/sqrt(d) approximation), then clamp.
  function automatic logic signed [DW-1:0] f_scale_sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SH;
    if (s > A_MAX)      s = A_MAX;
    else if (s < A_MIN) s = A_MIN;
    return s[DW-1:0];
  endfunction

  assign w_k_acc = bus.k_valid && (r_state == LOAD_K);
  assign w_q_acc = bus.q_valid && (r_state == WAIT_Q);
  assign w_s_hs  = bus.s_ready && (r_state == EMIT);

  // The score for the next output slot: col 0 of the arriving query, or col+1 of the held one.
  assign w_col_sel = (r_state == EMIT) ? r_col + CW'(1) : '0;
  assign w_q_sel   = (r_state == EMIT) ? r_q : bus.q_data;
  assign w_k_sel   = r_kbuf[w_col_sel];

  always_comb begin
    w_acc = '0;
    for (int e = 0; e < TOKEN_DIM; e++) begin
      w_acc = w_acc + ACC_W'(f_mul(w_q_sel[e*DW +: DW], w_k_sel[e*DW +: DW]));
    end
  end

  assign w_score = (r_causal && (w_col_sel > r_row)) ? S_MIN : f_scale_sat(w_acc);

  always_ff @(posedge clk) begin
    if (w_k_acc) r_kbuf[r_k_cnt] <= bus.k_data;
    if (w_q_acc) r_q <= bus.q_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LOAD_K;
      r_k_cnt   <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_causal  <= 1'b0;
      r_k_ready <= 1'b1;
      r_q_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_s_valid <= 1'b0;
      r_s_last  <= 1'b0;
      r_s_data  <= '0;
      r_s_row   <= '0;
      r_s_col   <= '0;
    end else begin
      case (r_state)
        LOAD_K: begin
          if (w_k_acc) begin
            r_busy <= 1'b1;
            if (r_k_cnt == LAST) begin
              r_k_cnt   <= '0;
              r_causal  <= bus.causal_en;
              r_row     <= '0;
              r_k_ready <= 1'b0;
              r_q_ready <= 1'b1;
              r_state   <= WAIT_Q;
            end else begin
              r_k_cnt <= r_k_cnt + CW'(1);
            end
          end
        end
        WAIT_Q: begin
          if (w_q_acc) begin
            r_col     <= '0;
            r_q_ready <= 1'b0;
            r_s_valid <= 1'b1;
            r_s_data  <= w_score;
            r_s_row   <= r_row;
            r_s_col   <= '0;
            r_s_last  <= (r_row == LAST) && (LAST == '0);
            r_state   <= EMIT;
          end
        end
        EMIT: begin
          if (w_s_hs) begin
            if (r_col == LAST) begin
              r_s_valid <= 1'b0;
              r_s_last  <= 1'b0;
              if (r_row != LAST) begin
                r_row     <= r_row + CW'(1);
                r_q_ready <= 1'b1;
                r_state   <= WAIT_Q;
              end else begin
                r_k_ready <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= LOAD_K;
              end
            end else begin
              r_col    <= w_col_sel;
              r_s_data <= w_score;
              r_s_col  <= w_col_sel;
              r_s_last <= (r_row == LAST) && (w_col_sel == LAST);
            end
          end
        end
        default: r_state <= LOAD_K;
      endcase
    end
  end

  assign bus.k_ready = r_k_ready;
  assign bus.q_ready = r_q_ready;
  assign bus.busy    = r_busy;
  assign bus.s_valid = r_s_valid;
  assign bus.s_data  = r_s_data;
  assign bus.s_row   = r_s_row;
  assign bus.s_col   = r_s_col;
  assign bus.s_last  = r_s_last;
endmodule

// File: tb/tb_attn_score_stream.sv
// Bench for attn_score_stream: directed batches checked every handshake against
// an arithmetic score model, plus literal spot values and reset/stall checks.
module tb_attn_score_stream;
  logic clk;
  logic rst_n;

  attn_score_if #(.DATA_WIDTH(16), .TOKEN_DIM(4), .TOKEN_NUM(8)) bus ();

  attn_score_stream #(
    .DATA_WIDTH(16), .FRAC_BITS(8), .TOKEN_DIM(4), .TOKEN_NUM(8), .SCALE_SHIFT(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] m_k [8];
  logic [63:0] m_q [8];
  bit          m_causal;
  int          h_idx = 0;
  int          base  = 0;
  logic [15:0] cap [64];
  bit          rnd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected score straight from the definition: dot product, floor /512, clamp.
  function automatic logic [15:0] model(input int r, input int c);
    longint s;
    s = 0;
    if (m_causal && c > r) return 16'h8000;
    for (int e = 0; e < 4; e++) begin
      logic signed [15:0] a;
      logic signed [15:0] b;
      a = m_q[r][16*e +: 16];
      b = m_k[c][16*e +: 16];
      s = s + longint'(a) * longint'(b);
    end
    s = s >>> 9;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  initial begin
    bus.s_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.s_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  bit          stall, chk_q, chk_k;
  logic [15:0] p_data;
  logic [2:0]  p_row, p_col;
  logic        p_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 0;
      chk_q = 0;
      chk_k = 0;
    end else begin
      if (stall) begin
        chk("stall_data", bus.s_data, p_data);
        chk("stall_row", bus.s_row, p_row);
        chk("stall_col", bus.s_col, p_col);
        chk("stall_last", bus.s_last, p_last);
      end
      if (chk_q) chk("next_row_q_ready", bus.q_ready, 1'b1);
      if (chk_k) begin
        chk("batch_end_k_ready", bus.k_ready, 1'b1);
        chk("batch_end_busy", bus.busy, 1'b0);
      end
      chk_q = 0;
      chk_k = 0;
      if (bus.s_valid && bus.s_ready) begin
        int idx;
        idx = h_idx - base;
        chk("hs_in_range", 32'(idx < 64), 1);
        if (idx < 64) begin
          chk("s_row", bus.s_row, idx / 8);
          chk("s_col", bus.s_col, idx % 8);
          chk("s_data", bus.s_data, model(idx / 8, idx % 8));
          chk("s_last", bus.s_last, 32'(idx == 63));
          cap[idx] = bus.s_data;
          if (idx % 8 == 7) begin
            if (idx == 63) chk_k = 1;
            else           chk_q = 1;
          end
        end
        h_idx++;
      end
      stall  = bus.s_valid && !bus.s_ready;
      p_data = bus.s_data;
      p_row  = bus.s_row;
      p_col  = bus.s_col;
      p_last = bus.s_last;
    end
  end

  task automatic send_k(input logic [63:0] d);
    int t;
    t = 0;
    @(negedge clk);
    bus.k_valid = 1'b1;
    bus.k_data  = d;
    while (!bus.k_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("k_accept_timeout", 0, 1);
    @(negedge clk);
    bus.k_valid = 1'b0;
  endtask

  task automatic send_q(input logic [63:0] d, input int row);
    int t;
    t = 0;
    @(negedge clk);
    bus.q_valid = 1'b1;
    bus.q_data  = d;
    while (!bus.q_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("q_accept_timeout", 0, 1);
    else          chk("wait_q_k_ready", bus.k_ready, 1'b0);
    @(negedge clk);
    bus.q_valid = 1'b0;
    chk("first_score_latency", bus.s_valid, 1'b1);
    chk("first_score_row", bus.s_row, row);
  endtask

  task automatic fill(input logic [15:0] kv, input logic [15:0] qv);
    for (int i = 0; i < 8; i++) begin
      m_k[i] = {4{kv}};
      m_q[i] = {4{qv}};
    end
  endtask

  task automatic run_batch(input bit causal, input bit flip, input bit junk);
    int t;
    base        = h_idx;
    m_causal    = causal;
    bus.causal_en = causal;
    for (int i = 0; i < 8; i++) begin
      send_k(m_k[i]);
      if (i == 0) chk("busy_after_first_k", bus.busy, 1'b1);
    end
    if (flip) bus.causal_en = ~causal;
    if (junk) begin
      bus.k_valid = 1'b1;
      bus.k_data  = 64'h1234_5678_9ABC_DEF0;
    end
    for (int r = 0; r < 8; r++) send_q(m_q[r], r);
    bus.k_valid = 1'b0;
    t = 0;
    while (h_idx - base < 64 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk("hs_count", h_idx - base, 64);
    chk("idle_s_valid", bus.s_valid, 1'b0);
    chk("idle_k_ready", bus.k_ready, 1'b1);
  endtask

  initial begin
    int t;
    rst_n         = 1'b0;
    bus.causal_en = 1'b0;
    bus.k_valid   = 1'b0;
    bus.k_data    = '0;
    bus.q_valid   = 1'b0;
    bus.q_data    = '0;
    repeat (3) @(negedge clk);
    chk("rst_s_valid", bus.s_valid, 1'b0);
    chk("rst_s_data", bus.s_data, 16'h0000);
    chk("rst_s_last", bus.s_last, 1'b0);
    chk("rst_k_ready", bus.k_ready, 1'b1);
    chk("rst_q_ready", bus.q_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;

    fill(16'h0100, 16'h0080);
    m_causal = 0;
    chk("model_c1", model(3, 5), 16'h0100);
    m_causal = 1;
    chk("model_mask", model(0, 1), 16'h8000);
    chk("model_diag", model(1, 1), 16'h0100);

    // uniform batch, with ignored k_valid during the query phase
    fill(16'h0100, 16'h0080);
    run_batch(0, 0, 1);
    chk("c1_first", cap[0], 16'h0100);
    chk("c1_last", cap[63], 16'h0100);

    // mixed-sign dot product, then its negation
    fill(16'h0000, 16'h0000);
    m_k[0] = {4{16'h0080}};
    m_q[0] = {16'hFF00, 16'h0000, 16'h0200, 16'h0100};
    run_batch(0, 0, 0);
    chk("c2_pos", cap[0], 16'h0080);
    chk("c2_zero", cap[1], 16'h0000);
    m_q[0] = {16'h0100, 16'h0000, 16'hFE00, 16'hFF00};
    run_batch(0, 0, 0);
    chk("c2_neg", cap[0], 16'hFF80);

    // causal mask, flipped mid-batch without effect
    fill(16'h0100, 16'h0080);
    run_batch(1, 1, 0);
    chk("c3_r0c0", cap[0], 16'h0100);
    chk("c3_r0c1", cap[1], 16'h8000);
    chk("c3_r0c7", cap[7], 16'h8000);
    chk("c3_r7c0", cap[56], 16'h0100);
    chk("c3_r7c7", cap[63], 16'h0100);

    // saturation both ways
    fill(16'h7FFF, 16'h7FFF);
    run_batch(0, 0, 0);
    chk("c4_pos_sat", cap[10], 16'h7FFF);
    fill(16'h7FFF, 16'h8000);
    run_batch(0, 0, 0);
    chk("c4_neg_sat", cap[10], 16'h8000);

    // random backpressure
    rnd = 1;
    fill(16'h0100, 16'h0080);
    run_batch(0, 0, 0);
    rnd = 0;
    repeat (2) @(negedge clk);
    chk("c5_mid", cap[37], 16'h0100);

    // asynchronous reset in the middle of row 2
    fill(16'h0100, 16'h0080);
    base          = h_idx;
    m_causal      = 0;
    bus.causal_en = 0;
    for (int i = 0; i < 8; i++) send_k(m_k[i]);
    for (int r = 0; r < 3; r++) send_q(m_q[r], r);
    t = 0;
    while (!(bus.s_valid && bus.s_row == 3'd2 && bus.s_col == 3'd3) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("c6_reached_r2c3", 32'(t < 100), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("c6_s_valid", bus.s_valid, 1'b0);
    chk("c6_k_ready", bus.k_ready, 1'b1);
    chk("c6_q_ready", bus.q_ready, 1'b0);
    chk("c6_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    fill(16'h0100, 16'h0100);
    run_batch(0, 0, 0);
    chk("c6_reload", cap[0], 16'h0200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
